uart_tx_param: RTL and testbench

Parametrised UART transmitter: the next-generation replacement for the fixed 8N1 transmitter. Serialises words of configurable width with optional parity and one or two stop bits, timed from an external oversampling tick (driven by the baud-rate generator). Words are queued in an internal FIFO, so frames go out back-to-back with no idle gap. Sits between the bus-side producer and the `tx` pad.

---
 rtl/uart_tx_param.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable width, parity and stop bits, paced by an oversampling tick.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry word FIFO; otherwise a single holding register queues one word.
module uart_tx_param #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] d_in,
  input  logic                 tx_start,
  output logic                 tx,
  output logic                 tx_done,
  output logic                 busy,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 overflow
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic                 push;
  logic                 pop;
  logic                 q_full;
  logic                 q_empty;
  logic [DATA_BITS-1:0] head_word;
  logic                 ovf_q;

  // Full is sampled before any same-cycle pop, so a write into a full queue is always dropped.
  assign push = tx_start && !q_full;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW:0]          count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= d_in;
  end

  assign head_word = mem_q[rd_ptr_q];
  assign q_full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign q_empty   = (count_q == '0);
`else
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_vld_q;
  logic                 unused_depth;

  assign unused_depth = (FIFO_DEPTH > 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else if (push) begin
      hold_q     <= d_in;
      hold_vld_q <= 1'b1;
    end else if (pop) begin
      hold_vld_q <= 1'b0;
    end
  end

  assign head_word = hold_q;
  assign q_full    = hold_vld_q;
  assign q_empty   = !hold_vld_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= tx_start && q_full;
  end

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end;
  logic                 start_frame;

  assign bit_end = (tick_cnt_q == TW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  // The shift register always presents the next data bit at bit 0.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    start_frame = 1'b0;
    if (baud_tick) begin
      if (state_q != S_IDLE) tick_cnt_d = bit_end ? '0 : tick_cnt_q + TW'(1);
      case (state_q)
        S_IDLE: start_frame = !q_empty;
        S_START: if (bit_end) begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
        S_DATA: if (bit_end) begin
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            if (PARITY_MODE != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
        S_PARITY: if (bit_end) begin
          state_d   = S_STOP;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
        S_STOP: if (bit_end) begin
          if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
            done_d      = 1'b1;
            bit_cnt_d   = '0;
            state_d     = S_IDLE;
            start_frame = !q_empty;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
      // The tick that ends a frame may also open the next one, keeping frames gap-free.
      if (start_frame) begin
        pop        = 1'b1;
        state_d    = S_START;
        tx_d       = 1'b0;
        tick_cnt_d = '0;
        shift_d    = head_word;
        par_d      = (^head_word) ^ (PARITY_MODE == 1);
      end
    end
  end

  assign tx         = tx_q;
  assign tx_done    = done_q;
  assign busy       = (state_q != S_IDLE);
  assign fifo_full  = q_full;
  assign fifo_empty = q_empty;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three framings driven in parallel, each checked every clk
// against a frame-level line model and a bounded word queue.
module tb_uart_tx_param;
  localparam int OS = 16;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       tx_start = 1'b0;
  logic [2:0] tx_w, done_w, busy_w, full_w, empty_w, ovf_w;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .d_in(d_in), .tx_start(tx_start),
    .tx(tx_w[0]), .tx_done(done_w[0]), .busy(busy_w[0]), .fifo_full(full_w[0]),
    .fifo_empty(empty_w[0]), .overflow(ovf_w[0]));

  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) u_8e2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .d_in(d_in), .tx_start(tx_start),
    .tx(tx_w[1]), .tx_done(done_w[1]), .busy(busy_w[1]), .fifo_full(full_w[1]),
    .fifo_empty(empty_w[1]), .overflow(ovf_w[1]));

  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .d_in(d_in), .tx_start(tx_start),
    .tx(tx_w[2]), .tx_done(done_w[2]), .busy(busy_w[2]), .fifo_full(full_w[2]),
    .fifo_empty(empty_w[2]), .overflow(ovf_w[2]));

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, one slot per instance.
  logic [7:0] mbuf [3][8];
  int         mhd [3];
  int         mcnt [3];
  bit         act [3];
  int         pos [3];
  logic [7:0] cur [3];
  bit         exp_done [3];
  bit         exp_ovf [3];
  int         ph = 0;
  bit         ticks_on = 1'b1;

  function automatic int pm(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction

  function automatic int sb(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int flen(input int i);
    return OS * (1 + 8 + ((pm(i) != 0) ? 1 : 0) + sb(i));
  endfunction

  // Line level for bit slot k of a frame: start, 8 data LSB first, optional parity, stop bits.
  function automatic logic exp_bit(input int i, input logic [7:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return w[k-1];
    if (pm(i) != 0 && k == 9) return (pm(i) == 2) ? (^w) : ~(^w);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mhd[i] = 0; mcnt[i] = 0; act[i] = 0; pos[i] = 0;
      exp_done[i] = 0; exp_ovf[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit tk, input bit st, input logic [7:0] dv);
    bit pre_full;
    bit pre_empty;
    pre_full  = (mcnt[i] >= CAP);
    pre_empty = (mcnt[i] == 0);
    exp_done[i] = 1'b0;
    exp_ovf[i]  = st && pre_full;
    if (tk) begin
      if (act[i]) begin
        pos[i]++;
        if (pos[i] == flen(i)) begin
          exp_done[i] = 1'b1;
          act[i] = 1'b0;
        end
      end
      if (!act[i] && !pre_empty) begin
        cur[i] = mbuf[i][mhd[i]];
        mhd[i] = (mhd[i] + 1) % 8;
        mcnt[i]--;
        act[i] = 1'b1;
        pos[i] = 0;
      end
    end
    if (st && !pre_full) begin
      mbuf[i][(mhd[i] + mcnt[i]) % 8] = dv;
      mcnt[i]++;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tx%0d", i), tx_w[i], act[i] ? exp_bit(i, cur[i], pos[i] / OS) : 1'b1);
      chk($sformatf("tx_done%0d", i), done_w[i], exp_done[i]);
      chk($sformatf("busy%0d", i), busy_w[i], act[i]);
      chk($sformatf("fifo_full%0d", i), full_w[i], mcnt[i] >= CAP);
      chk($sformatf("fifo_empty%0d", i), empty_w[i], mcnt[i] == 0);
      chk($sformatf("overflow%0d", i), ovf_w[i], exp_ovf[i]);
    end
  endtask

  task automatic reset_checks();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tx%0d", i), tx_w[i], 1'b1);
      chk($sformatf("rst_done%0d", i), done_w[i], 1'b0);
      chk($sformatf("rst_busy%0d", i), busy_w[i], 1'b0);
      chk($sformatf("rst_full%0d", i), full_w[i], 1'b0);
      chk($sformatf("rst_empty%0d", i), empty_w[i], 1'b1);
      chk($sformatf("rst_ovf%0d", i), ovf_w[i], 1'b0);
    end
  endtask

  // One clk: drive inputs, advance the model on the edge, compare 1 ns later.
  task automatic step(input bit st, input logic [7:0] dv);
    bit tk;
    tk = ticks_on && (ph == 0);
    ph = (ph + 1) % 2;
    baud_tick = tk; tx_start = st; d_in = dv;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, tk, st, dv);
    #1;
    baud_tick = 1'b0; tx_start = 1'b0;
    check_all();
  endtask

  function automatic bit quiet();
    for (int i = 0; i < 3; i++) if (act[i] || mcnt[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!quiet() && n < budget) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk(tag, (~|busy_w) && (&empty_w), 1'b1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    rst_n = 1'b1;

    // Single 0x99 frame, then 0xDA (parity cases).
    step(1'b1, 8'h99);
    drain("drain_99", 4000);
    step(1'b1, 8'hDA);
    drain("drain_da", 4000);

    // Consecutive writes: back-to-back frames when the queue can hold the second word.
    step(1'b1, 8'h99);
    step(1'b1, 8'hDA);
    drain("drain_b2b", 8000);

    // Six writes with the line stalled: queue fills, later writes overflow.
    ticks_on = 1'b0;
    for (int k = 0; k < 6; k++) step(1'b1, 8'($urandom_range(0, 255)));
    repeat (3) step(1'b0, 8'h00);
    ticks_on = 1'b1;
    drain("drain_stall", 20000);

    // Three writes while idle, then reset asserted during data bit 3 of the first frame.
    step(1'b1, 8'h3C);
    step(1'b1, 8'hA5);
    step(1'b1, 8'h5A);
    for (int n = 0; n < 4000 && !(act[0] && pos[0] >= 4 * OS + 3); n++) step(1'b0, 8'h00);
    chk("reached_data3", busy_w[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    reset_checks();
    @(posedge clk);
    #1;
    reset_checks();
    #2 rst_n = 1'b1;
    repeat (800) step(1'b0, 8'h00);

    // Randomised writes with random gaps.
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 300)) step(1'b0, 8'h00);
    end
    drain("drain_rand", 20000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
